tiny_dnn_csr: RTL and testbench

Parametrised AXI4-Lite control/status register bank for the tiny-dnn accelerator, the successor to the fixed 16-entry register file. It sits between the PS AXI-Lite master and the convolution/FC datapath. It supports:
- a configurable number of 32-bit parameter registers exported as a flat vector;
- byte strobes and SLVERR on unmapped addresses;
- independent read and write channels;
- a self-clearing start pulse, a sticky done flag and a maskable interrupt.

---
 rtl/tiny_dnn_csr_pkg.sv | 45 ++++
 rtl/tiny_dnn_axil_slave.sv | 126 ++++++++++++
 rtl/tiny_dnn_csr.sv | 141 ++++++++++++++
 tb/tb_tiny_dnn_csr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_csr_pkg.sv
// Shared constants and helpers for the tiny-dnn AXI4-Lite control/status register bank.
package tiny_dnn_csr_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned MODE_W = 7;

  // Register word indices
  localparam logic [IDX_W-1:0] IDX_CTRL   = 6'd0;
  localparam logic [IDX_W-1:0] IDX_STATUS = 6'd1;
  localparam logic [IDX_W-1:0] IDX_IRQEN  = 6'd2;
  localparam int unsigned      PARAM_BASE = 3;

  // Bit positions
  localparam int unsigned CTRL_START_BIT       = 8;
  localparam int unsigned STATUS_BUSY_BIT      = 0;
  localparam int unsigned STATUS_DONE_BIT      = 1;
  localparam int unsigned STATUS_SRC_READY_BIT = 31;
  localparam int unsigned IRQEN_DONE_BIT       = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // True when a word index decodes to CTRL/STATUS/IRQEN or a parameter register
  function automatic logic idx_mapped(input logic [IDX_W-1:0] idx, input int unsigned nparam);
    return 32'(idx) < (PARAM_BASE + nparam);
  endfunction

  // Replace only the byte lanes whose strobe is set
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tiny_dnn_axil_slave.sv
// AXI4-Lite channel handshakes with one-entry AW/W holding registers; presents
// single-cycle write/read strobes to the register bank.
module tiny_dnn_axil_slave
  import tiny_dnn_csr_pkg::*;
#(
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [STRB_W-1:0] S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              wr_en_c,
  output logic [IDX_W-1:0]  wr_idx_c,
  output logic [DATA_W-1:0] wr_data_c,
  output logic [STRB_W-1:0] wr_strb_c,
  input  logic [1:0]        wr_resp_c,
  output logic              rd_en_c,
  output logic [IDX_W-1:0]  rd_idx_c,
  input  logic [DATA_W-1:0] rd_data_c,
  input  logic [1:0]        rd_resp_c
);

  logic              ready_en_q;
  logic              aw_held_q;
  logic              w_held_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              aw_fire;
  logic              w_fire;
  logic [ADDR_W-1:0] wr_addr_c;

  assign S_AXI_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID & S_AXI_WREADY;

  // Commit once both halves are present, whether held or arriving this cycle
  assign wr_en_c   = (aw_held_q | aw_fire) & (w_held_q | w_fire);
  assign wr_addr_c = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_idx_c  = wr_addr_c[ADDR_LSB +: IDX_W];
  assign wr_data_c = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb_c = w_held_q ? w_strb_q : S_AXI_WSTRB;

  assign rd_en_c  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign rd_idx_c = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  // Keeps all readys low during reset, high from the first cycle after release
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en_q <= 1'b0;
    else                ready_en_q <= 1'b1;
  end

  // Write channel: capture AW/W, commit, and hold the response until BREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else if (bvalid_q) begin
      if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end else if (wr_en_c) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_resp_c;
    end else begin
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Read channel: register data on AR handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (rd_en_c) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_c;
      rresp_q  <= rd_resp_c;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tiny_dnn_csr.sv
// Control/status register bank for the tiny-dnn datapath: mode/start control,
// sticky done with maskable interrupt, and NPARAM exported parameter words.
module tiny_dnn_csr
  import tiny_dnn_csr_pkg::*;
#(
  parameter int unsigned NPARAM   = 16,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_W-1:0]        S_AXI_WDATA,
  input  logic [STRB_W-1:0]        S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_W-1:0]        S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic                     src_ready,
  input  logic                     busy,
  input  logic                     done,
  output logic [MODE_W-1:0]        mode,
  output logic                     start,
  output logic                     irq,
  output logic [DATA_W*NPARAM-1:0] param
);

  logic                          wr_en;
  logic [IDX_W-1:0]              wr_idx;
  logic [DATA_W-1:0]             wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic [1:0]                    wr_resp_c;
  logic                          unused_rd_en;
  logic [IDX_W-1:0]              rd_idx;
  logic [DATA_W-1:0]             rd_data_c;
  logic [1:0]                    rd_resp_c;
  logic [MODE_W-1:0]             mode_q;
  logic                          start_q;
  logic                          done_q;
  logic                          irqen_q;
  logic                          irq_q;
  logic [NPARAM-1:0][DATA_W-1:0] param_q;
  logic                          done_clr_c;

  tiny_dnn_axil_slave #(.ADDR_LSB(ADDR_LSB)) u_slave (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .wr_en_c       (wr_en),
    .wr_idx_c      (wr_idx),
    .wr_data_c     (wr_data),
    .wr_strb_c     (wr_strb),
    .wr_resp_c     (wr_resp_c),
    .rd_en_c       (unused_rd_en),
    .rd_idx_c      (rd_idx),
    .rd_data_c     (rd_data_c),
    .rd_resp_c     (rd_resp_c)
  );

  assign mode  = mode_q;
  assign start = start_q;
  assign irq   = irq_q;
  assign param = param_q;

  assign wr_resp_c  = idx_mapped(wr_idx, NPARAM) ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp_c  = idx_mapped(rd_idx, NPARAM) ? RESP_OKAY : RESP_SLVERR;
  assign done_clr_c = wr_en & (wr_idx == IDX_STATUS) & wr_strb[0] & wr_data[STATUS_DONE_BIT];

  // Read mux from current register state; unmapped indices return zero
  always_comb begin
    rd_data_c = '0;
    case (rd_idx)
      IDX_CTRL:   rd_data_c[MODE_W-1:0] = mode_q;
      IDX_STATUS: begin
        rd_data_c[STATUS_BUSY_BIT]      = busy;
        rd_data_c[STATUS_DONE_BIT]      = done_q;
        rd_data_c[STATUS_SRC_READY_BIT] = src_ready;
      end
      IDX_IRQEN:  rd_data_c[IRQEN_DONE_BIT] = irqen_q;
      default: begin
        for (int k = 0; k < int'(NPARAM); k++) begin
          if (rd_idx == IDX_W'(PARAM_BASE + k)) rd_data_c = param_q[k];
        end
      end
    endcase
  end

  // Control, flag and interrupt registers; a coincident done beats the W1C clear
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      mode_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      start_q <= wr_en & (wr_idx == IDX_CTRL) & wr_strb[1] & wr_data[CTRL_START_BIT];
      if (wr_en && (wr_idx == IDX_CTRL) && wr_strb[0]) mode_q <= wr_data[MODE_W-1:0];
      if (wr_en && (wr_idx == IDX_IRQEN) && wr_strb[0]) irqen_q <= wr_data[IRQEN_DONE_BIT];
      done_q <= done | (done_q & ~done_clr_c);
      irq_q  <= done_q & irqen_q;
    end
  end

  // Parameter registers with per-byte strobes
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      param_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < int'(NPARAM); k++) begin
        if (wr_idx == IDX_W'(PARAM_BASE + k)) param_q[k] <= strb_merge(param_q[k], wr_data, wr_strb);
      end
    end
  end

endmodule

// File: tb/tb_tiny_dnn_csr.sv
// Directed self-checking bench for tiny_dnn_csr (NPARAM=16, ADDR_LSB=2).
module tb_tiny_dnn_csr;

  logic         clk;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic         src_ready;
  logic         busy;
  logic         done;
  logic [6:0]   mode;
  logic         start;
  logic         irq;
  logic [511:0] param;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  tiny_dnn_csr #(.NPARAM(16), .ADDR_LSB(2)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .src_ready     (src_ready),
    .busy          (busy),
    .done          (done),
    .mode          (mode),
    .start         (start),
    .irq           (irq),
    .param         (param)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AW and W presented together; returns BRESP, releases BVALID with BREADY high
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_f;
    logic w_f;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      aw_f = awvalid & awready;
      w_f  = wvalid & wready;
      @(negedge clk);
      if (aw_f) awvalid = 1'b0;
      if (w_f)  wvalid  = 1'b0;
    end
    chk("wr_handshake_timeout", 64'(awvalid | wvalid), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", 64'(bvalid), 64'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ar_f;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      ar_f = arvalid & arready;
      @(negedge clk);
      if (ar_f) arvalid = 1'b0;
    end
    chk("rd_handshake_timeout", 64'(arvalid), 64'd0);
    arvalid = 1'b0;
    chk("rd_rvalid", 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    src_ready = 1'b0; busy = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_param", 64'(|param), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);

    // AW+W same cycle to idx 3
    @(negedge clk);
    awaddr = 32'd12; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_param0", 64'(param[31:0]), 64'hDEADBEEF);
    chk("t1_bvalid", 64'(bvalid), 64'd1);
    chk("t1_bresp", 64'(bresp), 64'd0);
    chk("t1_awready_blocked", 64'(awready), 64'd0);
    bready = 1'b1;
    @(negedge clk);
    chk("t1_bvalid_clr", 64'(bvalid), 64'd0);
    bready = 1'b0;

    // W two cycles ahead of AW, idx 4, low half-word strobes
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1; awaddr = 32'd16;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t2_wready_held", 64'(wready), 64'd0);
    chk("t2_no_bvalid_a", 64'(bvalid), 64'd0);
    @(negedge clk);
    chk("t2_no_commit", 64'(param[63:32]), 64'd0);
    chk("t2_no_bvalid_b", 64'(bvalid), 64'd0);
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("t2_param1", 64'(param[63:32]), 64'h00005678);
    chk("t2_bvalid", 64'(bvalid), 64'd1);
    chk("t2_bresp", 64'(bresp), 64'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;

    // CTRL write: mode plus one-cycle start pulse
    @(negedge clk);
    awaddr = 32'd0; wdata = 32'h0000017F; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t3_start_hi", 64'(start), 64'd1);
    chk("t3_mode", 64'(mode), 64'h7F);
    @(negedge clk);
    chk("t3_start_lo", 64'(start), 64'd0);
    bready = 1'b0;
    axi_read(32'd0, rd_d, rd_r);
    chk("t3_ctrl_rd", 64'(rd_d), 64'h7F);
    chk("t3_ctrl_rresp", 64'(rd_r), 64'd0);

    // done -> sticky flag -> irq two cycles later
    axi_write(32'd8, 32'h2, 4'hF, wr_r);
    chk("t4_irqen_bresp", 64'(wr_r), 64'd0);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t4_irq_lat1", 64'(irq), 64'd0);
    @(negedge clk);
    chk("t4_irq_lat2", 64'(irq), 64'd1);
    axi_read(32'd4, rd_d, rd_r);
    chk("t4_status", 64'(rd_d), 64'h2);
    busy = 1'b1; src_ready = 1'b1;
    axi_read(32'd4, rd_d, rd_r);
    chk("t4_status_ro", 64'(rd_d), 64'h80000003);
    busy = 1'b0; src_ready = 1'b0;

    // W1C without byte-0 strobe must not clear
    axi_write(32'd4, 32'h2, 4'hE, wr_r);
    axi_read(32'd4, rd_d, rd_r);
    chk("t4_w1c_nostrb", 64'(rd_d), 64'h2);

    // W1C coinciding with done: set wins
    @(negedge clk);
    awaddr = 32'd4; wdata = 32'h2; wstrb = 4'h1;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; done = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
    chk("t4_coinc_bvalid", 64'(bvalid), 64'd1);
    @(negedge clk);
    bready = 1'b0;
    axi_read(32'd4, rd_d, rd_r);
    chk("t4_set_wins", 64'(rd_d), 64'h2);

    // Plain W1C clears flag and irq
    axi_write(32'd4, 32'h2, 4'h1, wr_r);
    axi_read(32'd4, rd_d, rd_r);
    chk("t4_w1c_clear", 64'(rd_d), 64'h0);
    chk("t4_irq_clear", 64'(irq), 64'd0);

    // Unmapped index 63 and the last/first-past parameter boundary
    axi_read(32'hFC, rd_d, rd_r);
    chk("t5_unmapped_rdata", 64'(rd_d), 64'd0);
    chk("t5_unmapped_rresp", 64'(rd_r), 64'h2);
    axi_write(32'hFC, 32'hFFFFFFFF, 4'hF, wr_r);
    chk("t5_unmapped_bresp", 64'(wr_r), 64'h2);
    chk("t5_param0_kept", 64'(param[31:0]), 64'hDEADBEEF);
    chk("t5_mode_kept", 64'(mode), 64'h7F);
    axi_write(32'd72, 32'hCAFEF00D, 4'hF, wr_r);
    chk("t5_last_bresp", 64'(wr_r), 64'd0);
    chk("t5_last_param", 64'(param[511:480]), 64'hCAFEF00D);
    axi_write(32'd76, 32'h11111111, 4'hF, wr_r);
    chk("t5_past_bresp", 64'(wr_r), 64'h2);
    axi_read(32'd76, rd_d, rd_r);
    chk("t5_past_rresp", 64'(rd_r), 64'h2);

    // Single byte-lane update and parameter readback
    axi_write(32'd12, 32'h00AA0000, 4'h4, wr_r);
    chk("t6_byte2", 64'(param[31:0]), 64'hDEAABEEF);
    axi_read(32'd16, rd_d, rd_r);
    chk("t6_param1_rd", 64'(rd_d), 64'h00005678);

    // Reset with a pending response
    @(negedge clk);
    awaddr = 32'd12; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t7_bvalid_pend", 64'(bvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_bvalid_async", 64'(bvalid), 64'd0);
    chk("t7_awready_rst", 64'(awready), 64'd0);
    chk("t7_param_rst", 64'(|param), 64'd0);
    chk("t7_mode_rst", 64'(mode), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_awready", 64'(awready), 64'd1);
    chk("t7_wready", 64'(wready), 64'd1);
    chk("t7_arready", 64'(arready), 64'd1);
    chk("t7_bvalid", 64'(bvalid), 64'd0);
    chk("t7_outs", 64'({start, irq, mode}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
